// File: rtl/bcd_entry.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | bcd_entry : debounced keypad entry of 4 BCD digits, BCD->binary conv  |
// | Revision  : 1.0                                                       |
// +----------------------------------------------------------------------+
module bcd_entry #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNT_W           = 19
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        key_digit_n,
  input  logic        key_enter_n,
  input  logic        key_clear_n,
  input  logic [3:0]  sw_digit,
  output logic [15:0] bcd_out,
  output logic [13:0] value,
  output logic        valid,
  output logic        busy,
  output logic        err
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CONV = 2'd1,
    S_DONE = 2'd2
  } state_t;

  logic [2:0]  w_raw_n;
  logic [2:0]  w_press;
  logic [3:0]  w_nib;
  logic [13:0] w_acc_next;
  logic [15:0] w_mask;

  state_t      r_state;
  logic [15:0] r_work;
  logic [13:0] r_acc;
  logic [1:0]  r_idx;
  logic [2:0]  r_count;

  // bit 2 = clear, bit 1 = enter, bit 0 = digit
  assign w_raw_n = {key_clear_n, key_enter_n, key_digit_n};

  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_key
      logic             r_sync1;
      logic             r_sync2;
      logic             r_deb;
      logic             r_press;
      logic [CNT_W-1:0] r_cnt;

      always_ff @(posedge clk) begin
        if (!rst) begin
          r_sync1 <= 1'b1;
          r_sync2 <= 1'b1;
          r_deb   <= 1'b1;
          r_press <= 1'b0;
          r_cnt   <= '0;
        end else begin
          r_sync1 <= w_raw_n[gi];
          r_sync2 <= r_sync1;
          r_press <= 1'b0;
          if (r_sync2 == r_deb) begin
            r_cnt <= '0;
          end else if (r_cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
            // Only a released->pressed flip (old level 1) is a press event.
            r_deb   <= r_sync2;
            r_cnt   <= '0;
            r_press <= r_deb;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
      end

      assign w_press[gi] = r_press;
    end
  endgenerate

  assign w_nib      = r_work[{r_idx, 2'b00} +: 4];
  assign w_acc_next = (r_acc << 3) + (r_acc << 1) + {10'd0, w_nib};

  // Positions never filled since the last clear contribute zero.
  always_comb begin
    w_mask = 16'h0000;
    case (r_count)
      3'd1:    w_mask = 16'h000F;
      3'd2:    w_mask = 16'h00FF;
      3'd3:    w_mask = 16'h0FFF;
      3'd4:    w_mask = 16'hFFFF;
      default: w_mask = 16'h0000;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_work  <= 16'h0000;
      r_acc   <= 14'd0;
      r_idx   <= 2'd0;
      r_count <= 3'd0;
      bcd_out <= 16'h0000;
      value   <= 14'd0;
      valid   <= 1'b0;
      busy    <= 1'b0;
      err     <= 1'b0;
    end else begin
      valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_press[2]) begin
            bcd_out <= 16'h0000;
            r_count <= 3'd0;
            err     <= 1'b0;
          end else if (w_press[1]) begin
            r_work  <= bcd_out & w_mask;
            r_acc   <= 14'd0;
            r_idx   <= 2'd3;
            busy    <= 1'b1;
            r_state <= S_CONV;
          end else if (w_press[0]) begin
            if (sw_digit <= 4'd9) begin
              bcd_out <= {bcd_out[11:0], sw_digit};
              if (r_count != 3'd4) begin
                r_count <= r_count + 3'd1;
              end
              err <= 1'b0;
            end else begin
              err <= 1'b1;
            end
          end
        end
        S_CONV: begin
          r_acc <= w_acc_next;
          r_idx <= r_idx - 2'd1;
          if (r_idx == 2'd0) begin
            r_state <= S_DONE;
          end
        end
        S_DONE: begin
          value   <= r_acc;
          valid   <= 1'b1;
          busy    <= 1'b0;
          bcd_out <= 16'h0000;
          r_count <= 3'd0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_bcd_entry.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_bcd_entry : vector table plus scoreboard of converted values       |
// | Revision     : 1.0                                                    |
// +----------------------------------------------------------------------+
module tb_bcd_entry;

  localparam int OP_DIG = 0;
  localparam int OP_ENT = 1;
  localparam int OP_CLR = 2;
  localparam int NVEC   = 24;

  typedef struct {
    int          op;
    logic [3:0]  d;
    logic [15:0] bcd;
    logic        err;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        key_digit_n = 1'b1;
  logic        key_enter_n = 1'b1;
  logic        key_clear_n = 1'b1;
  logic [3:0]  sw_digit = 4'd0;
  logic [15:0] bcd_out;
  logic [13:0] value;
  logic        valid;
  logic        busy;
  logic        err;

  int   errors = 0;
  int   checks = 0;
  int   exp_q[$];
  logic prev_valid = 1'b0;

  bcd_entry #(.DEBOUNCE_CYCLES(4), .CNT_W(3)) dut (
    .clk(clk), .rst(rst),
    .key_digit_n(key_digit_n), .key_enter_n(key_enter_n), .key_clear_n(key_clear_n),
    .sw_digit(sw_digit), .bcd_out(bcd_out), .value(value),
    .valid(valid), .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int bcd2bin(input logic [15:0] b);
    return b[15:12] * 1000 + b[11:8] * 100 + b[7:4] * 10 + b[3:0];
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // mask bits: [2]=clear, [1]=enter, [0]=digit
  task automatic press(input logic [2:0] mask, input logic [3:0] d);
    sw_digit = d;
    if (mask[2]) key_clear_n = 1'b0;
    if (mask[1]) key_enter_n = 1'b0;
    if (mask[0]) key_digit_n = 1'b0;
    repeat (10) cyc();
    key_clear_n = 1'b1;
    key_enter_n = 1'b1;
    key_digit_n = 1'b1;
    repeat (10) cyc();
  endtask

  // Scoreboard: every valid pulse must match the oldest pending expectation.
  always @(negedge clk) begin
    if (rst !== 1'b1) begin
      prev_valid = 1'b0;
    end else begin
      if (valid === 1'b1) begin
        chk("valid_width", {31'd0, prev_valid}, 32'd0);
        if (exp_q.size() == 0) begin
          chk("unexpected_valid", 32'd1, 32'd0);
        end else begin
          chk("sb_value", {18'd0, value}, exp_q.pop_front());
        end
      end
      prev_valid = (valid === 1'b1);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t        tbl [NVEC];
    logic [15:0] prev_bcd;
    int          m_val;
    int          nb;
    bit          found;

    tbl[0]  = '{OP_CLR, 4'h0, 16'h0000, 1'b0};
    tbl[1]  = '{OP_DIG, 4'h1, 16'h0001, 1'b0};
    tbl[2]  = '{OP_DIG, 4'h2, 16'h0012, 1'b0};
    tbl[3]  = '{OP_DIG, 4'h3, 16'h0123, 1'b0};
    tbl[4]  = '{OP_DIG, 4'h4, 16'h1234, 1'b0};
    tbl[5]  = '{OP_ENT, 4'h0, 16'h0000, 1'b0};
    tbl[6]  = '{OP_DIG, 4'h9, 16'h0009, 1'b0};
    tbl[7]  = '{OP_DIG, 4'h8, 16'h0098, 1'b0};
    tbl[8]  = '{OP_DIG, 4'h7, 16'h0987, 1'b0};
    tbl[9]  = '{OP_DIG, 4'h6, 16'h9876, 1'b0};
    tbl[10] = '{OP_DIG, 4'h5, 16'h8765, 1'b0};
    tbl[11] = '{OP_DIG, 4'hC, 16'h8765, 1'b1};
    tbl[12] = '{OP_DIG, 4'h3, 16'h7653, 1'b0};
    tbl[13] = '{OP_ENT, 4'h0, 16'h0000, 1'b0};
    tbl[14] = '{OP_DIG, 4'h4, 16'h0004, 1'b0};
    tbl[15] = '{OP_DIG, 4'h2, 16'h0042, 1'b0};
    tbl[16] = '{OP_ENT, 4'h0, 16'h0000, 1'b0};
    tbl[17] = '{OP_DIG, 4'hA, 16'h0000, 1'b1};
    tbl[18] = '{OP_CLR, 4'h0, 16'h0000, 1'b0};
    tbl[19] = '{OP_DIG, 4'h5, 16'h0005, 1'b0};
    tbl[20] = '{OP_CLR, 4'h0, 16'h0000, 1'b0};
    tbl[21] = '{OP_DIG, 4'hF, 16'h0000, 1'b1};
    tbl[22] = '{OP_DIG, 4'h0, 16'h0000, 1'b0};
    tbl[23] = '{OP_ENT, 4'h0, 16'h0000, 1'b0};

    // Reset with all keys held pressed
    rst = 1'b0;
    key_digit_n = 1'b0;
    key_enter_n = 1'b0;
    key_clear_n = 1'b0;
    repeat (3) cyc();
    chk("rst_bcd", bcd_out, 16'h0000);
    chk("rst_value", value, 14'd0);
    chk("rst_valid", valid, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_err", err, 1'b0);
    key_digit_n = 1'b1;
    key_enter_n = 1'b1;
    key_clear_n = 1'b1;
    cyc();
    rst = 1'b1;
    repeat (15) cyc();
    chk("post_rst_bcd", bcd_out, 16'h0000);
    chk("post_rst_value", value, 14'd0);
    chk("post_rst_busy", busy, 1'b0);

    // Bouncing digit key, then a solid press
    sw_digit = 4'd7;
    for (int i = 0; i < 10; i++) begin
      key_digit_n = ~key_digit_n;
      repeat (2) cyc();
    end
    key_digit_n = 1'b0;
    repeat (10) cyc();
    key_digit_n = 1'b1;
    repeat (10) cyc();
    chk("bounce_bcd", bcd_out, 16'h0007);

    // Table-driven entry, error and conversion sequences
    prev_bcd = 16'h0007;
    m_val    = 0;
    for (int i = 0; i < NVEC; i++) begin
      case (tbl[i].op)
        OP_DIG: press(3'b001, tbl[i].d);
        OP_CLR: press(3'b100, tbl[i].d);
        default: begin
          m_val = bcd2bin(prev_bcd);
          exp_q.push_back(m_val);
          press(3'b010, tbl[i].d);
        end
      endcase
      chk($sformatf("vec%0d_bcd", i), bcd_out, tbl[i].bcd);
      chk($sformatf("vec%0d_err", i), err, tbl[i].err);
      chk($sformatf("vec%0d_value", i), value, m_val[13:0]);
      chk($sformatf("vec%0d_busy", i), busy, 1'b0);
      prev_bcd = tbl[i].bcd;
    end

    // Same-cycle events: enter beats digit, clear beats both
    press(3'b001, 4'd2);
    chk("prio_setup_bcd", bcd_out, 16'h0002);
    exp_q.push_back(2);
    press(3'b011, 4'd7);
    chk("prio_ent_bcd", bcd_out, 16'h0000);
    chk("prio_ent_value", value, 14'd2);
    press(3'b001, 4'd6);
    press(3'b111, 4'd1);
    chk("prio_clr_bcd", bcd_out, 16'h0000);
    chk("prio_clr_value", value, 14'd2);

    // Busy lockout with exact conversion timing
    press(3'b001, 4'd5);
    press(3'b001, 4'd1);
    chk("lock_setup_bcd", bcd_out, 16'h0051);
    exp_q.push_back(51);
    sw_digit = 4'd9;
    key_enter_n = 1'b0;
    cyc();
    key_digit_n = 1'b0;
    repeat (2) cyc();
    key_clear_n = 1'b0;
    found = 1'b0;
    for (int k = 0; k < 30; k++) begin
      cyc();
      if (busy === 1'b1) begin
        found = 1'b1;
        break;
      end
    end
    chk("lock_busy_seen", {31'd0, found}, 32'd1);
    nb = 1;
    chk("lock_bcd_busy", bcd_out, 16'h0051);
    for (int k = 0; k < 10; k++) begin
      cyc();
      if (busy !== 1'b1) break;
      nb++;
      chk("lock_bcd_busy", bcd_out, 16'h0051);
    end
    chk("lock_busy_cycles", nb, 5);
    chk("lock_valid_hi", valid, 1'b1);
    chk("lock_done_bcd", bcd_out, 16'h0000);
    cyc();
    chk("lock_valid_lo", valid, 1'b0);
    key_digit_n = 1'b1;
    key_enter_n = 1'b1;
    key_clear_n = 1'b1;
    repeat (12) cyc();
    chk("lock_after_bcd", bcd_out, 16'h0000);
    chk("lock_after_err", err, 1'b0);
    chk("lock_after_value", value, 14'd51);

    // Reset in the middle of a conversion
    press(3'b001, 4'd3);
    key_enter_n = 1'b0;
    found = 1'b0;
    for (int k = 0; k < 30; k++) begin
      cyc();
      if (busy === 1'b1) begin
        found = 1'b1;
        break;
      end
    end
    chk("mid_busy_seen", {31'd0, found}, 32'd1);
    repeat (2) cyc();
    rst = 1'b0;
    key_enter_n = 1'b1;
    repeat (3) cyc();
    chk("mid_value", value, 14'd0);
    chk("mid_busy", busy, 1'b0);
    chk("mid_valid", valid, 1'b0);
    chk("mid_bcd", bcd_out, 16'h0000);
    rst = 1'b1;
    repeat (12) cyc();
    chk("mid_after_value", value, 14'd0);
    chk("mid_after_busy", busy, 1'b0);

    // Enter with no digits entered
    exp_q.push_back(0);
    press(3'b010, 4'd0);
    chk("empty_value", value, 14'd0);
    chk("empty_bcd", bcd_out, 16'h0000);

    repeat (20) cyc();
    chk("sb_drain", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
